// File: rtl/exe_mem_stage_mc_if.sv
// Execute-stage bundle: ID/EX operands and controls in, stall/flag strobes and the EX/MEM register out.
interface exe_mem_stage_mc_if #(
  parameter int WIDTH = 32,
  parameter int RA    = 4
);
  logic             validE;
  logic [1:0]       fwdSelA, fwdSelB;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE;
  logic [WIDTH-1:0] forward_ResultW, forward_ALUResultM;
  logic             ALUSrcE;
  logic [2:0]       ALUControlE;
  logic [3:0]       condE, FlagsE;
  logic             FlagWE, RegWE, MemWE, MemtoRegE;
  logic [RA-1:0]    WA3E;
  logic             holdM, flushE;

  logic             stallE;
  logic [3:0]       FlagsOut;
  logic             FlagsWr;
  logic [WIDTH-1:0] ALUResultM, WriteDataM;
  logic [RA-1:0]    WA3M;
  logic             validM, RegWriteM, MemWriteM, MemtoRegM;

  modport master (
    output validE, fwdSelA, fwdSelB, RD1E, RD2E, ExtImmE, forward_ResultW, forward_ALUResultM,
           ALUSrcE, ALUControlE, condE, FlagsE, FlagWE, RegWE, MemWE, MemtoRegE, WA3E, holdM, flushE,
    input  stallE, FlagsOut, FlagsWr, ALUResultM, WriteDataM, WA3M, validM, RegWriteM, MemWriteM, MemtoRegM
  );

  modport slave (
    input  validE, fwdSelA, fwdSelB, RD1E, RD2E, ExtImmE, forward_ResultW, forward_ALUResultM,
           ALUSrcE, ALUControlE, condE, FlagsE, FlagWE, RegWE, MemWE, MemtoRegE, WA3E, holdM, flushE,
    output stallE, FlagsOut, FlagsWr, ALUResultM, WriteDataM, WA3M, validM, RegWriteM, MemWriteM, MemtoRegM
  );
endinterface

// File: rtl/exe_mem_stage_mc.sv
// ARM execute stage: forwarding, ALU, condition/NZCV, iterative multiplier and holdable EX/MEM register.
// ALU ops reach M after 1 edge, MUL after WIDTH/MUL_BITS+2; holdM freezes EX/MEM and raises stallE.
module exe_mem_stage_mc #(
  parameter int WIDTH    = 32,
  parameter int RA       = 4,
  parameter int MUL_BITS = 4
) (
  input logic               clk,
  input logic               rst,
  exe_mem_stage_mc_if.slave bus
);
  localparam int N  = WIDTH / MUL_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100, OP_MOV = 3'b101, OP_MUL = 3'b110, OP_BIC = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d, wd_q, wd_d;
  logic [RA-1:0]    wa3_q, wa3_d;
  logic             vld_q, vld_d, regw_q, regw_d, memw_q, memw_d, m2r_q, m2r_d;

  logic [WIDTH-1:0] src_a, mux_b, src_b, alu_res;
  logic [WIDTH:0]   sum;
  logic             f_n, f_z, f_c, f_v;
  logic             cond_ex, alu_c, alu_v, is_mul, start;
  logic             stall, flags_wr;
  logic [3:0]       flags_out;

  assign {f_n, f_z, f_c, f_v} = bus.FlagsE;

  always_comb begin
    case (bus.condE)
      4'b0000: cond_ex = f_z;
      4'b0001: cond_ex = ~f_z;
      4'b0010: cond_ex = f_c;
      4'b0011: cond_ex = ~f_c;
      4'b0100: cond_ex = f_n;
      4'b0101: cond_ex = ~f_n;
      4'b0110: cond_ex = f_v;
      4'b0111: cond_ex = ~f_v;
      4'b1000: cond_ex = f_c & ~f_z;
      4'b1001: cond_ex = ~f_c | f_z;
      4'b1010: cond_ex = (f_n == f_v);
      4'b1011: cond_ex = (f_n != f_v);
      4'b1100: cond_ex = ~f_z & (f_n == f_v);
      4'b1101: cond_ex = f_z | (f_n != f_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.fwdSelA)
      2'b01:   src_a = bus.forward_ResultW;
      2'b10:   src_a = bus.forward_ALUResultM;
      default: src_a = bus.RD1E;
    endcase
    case (bus.fwdSelB)
      2'b01:   mux_b = bus.forward_ResultW;
      2'b10:   mux_b = bus.forward_ALUResultM;
      default: mux_b = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ExtImmE : mux_b;

  // C and V default to the incoming flags; only ADD/SUB produce new ones.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = f_c;
    alu_v   = f_v;
    case (bus.ALUControlE)
      OP_ADD: begin
        sum     = {1'b0, src_a} + {1'b0, src_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_ORR:  alu_res = src_a | src_b;
      OP_EOR:  alu_res = src_a ^ src_b;
      OP_MOV:  alu_res = src_b;
      OP_BIC:  alu_res = src_a & ~src_b;
      default: alu_res = '0;
    endcase
  end

  assign is_mul = (bus.ALUControlE == OP_MUL);
  assign start  = bus.validE & cond_ex & is_mul & ~bus.flushE;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    stall     = bus.holdM;
    flags_wr  = 1'b0;
    flags_out = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    res_d     = res_q;
    wd_d      = wd_q;
    wa3_d     = wa3_q;
    vld_d     = vld_q;
    regw_d    = regw_q;
    memw_d    = memw_q;
    m2r_d     = m2r_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_MUL;
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          cnt_d    = '0;
          stall    = 1'b1;
        end else if (!bus.flushE) begin
          flags_wr = bus.validE & cond_ex & bus.FlagWE & ~is_mul;
        end
        if (!bus.holdM) begin
          if (start || bus.flushE) begin
            {vld_d, regw_d, memw_d, m2r_d} = '0;
            {res_d, wd_d, wa3_d}           = '0;
          end else begin
            res_d  = alu_res;
            wd_d   = mux_b;
            wa3_d  = bus.WA3E;
            vld_d  = bus.validE;
            regw_d = bus.validE & cond_ex & bus.RegWE;
            memw_d = bus.validE & cond_ex & bus.MemWE;
            m2r_d  = bus.validE & bus.MemtoRegE;
          end
        end
      end
      S_MUL: begin
        stall    = 1'b1;
        // Multiplicand shifts left as multiplier digits shift out, so each step adds one aligned partial product.
        acc_d    = acc_q + mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]);
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) state_d = S_DONE;
        if (bus.flushE) state_d = S_IDLE;
        if (!bus.holdM) begin
          {vld_d, regw_d, memw_d, m2r_d} = '0;
          {res_d, wd_d, wa3_d}           = '0;
        end
      end
      S_DONE: begin
        flags_out = {acc_q[WIDTH-1], (acc_q == '0), f_c, f_v};
        if (bus.flushE) begin
          state_d = S_IDLE;
          if (!bus.holdM) begin
            {vld_d, regw_d, memw_d, m2r_d} = '0;
            {res_d, wd_d, wa3_d}           = '0;
          end
        end else begin
          flags_wr = bus.FlagWE;
          if (!bus.holdM) begin
            state_d = S_IDLE;
            res_d   = acc_q;
            wd_d    = mux_b;
            wa3_d   = bus.WA3E;
            vld_d   = 1'b1;
            regw_d  = bus.RegWE;
            memw_d  = bus.MemWE;
            m2r_d   = bus.MemtoRegE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      wd_q     <= '0;
      wa3_q    <= '0;
      vld_q    <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      m2r_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      wd_q     <= wd_d;
      wa3_q    <= wa3_d;
      vld_q    <= vld_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      m2r_q    <= m2r_d;
    end
  end

  assign bus.stallE     = stall;
  assign bus.FlagsOut   = flags_out;
  assign bus.FlagsWr    = flags_wr;
  assign bus.ALUResultM = res_q;
  assign bus.WriteDataM = wd_q;
  assign bus.WA3M       = wa3_q;
  assign bus.validM     = vld_q;
  assign bus.RegWriteM  = regw_q;
  assign bus.MemWriteM  = memw_q;
  assign bus.MemtoRegM  = m2r_q;
endmodule

// File: tb/tb_exe_mem_stage_mc.sv
// Bench for exe_mem_stage_mc: directed vector table, hand-written MUL/hold/flush/reset sequences, random ALU ops vs model.
module tb_exe_mem_stage_mc;
  localparam int MUL_CYC = 8;

  logic clk = 1'b0;
  logic rst;
  exe_mem_stage_mc_if bus ();
  exe_mem_stage_mc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, fw, fm;
    logic        asrc;
    logic [2:0]  op;
    logic [3:0]  cc, fl;
    logic        fwe, rwe, mwe;
    logic [31:0] e_res;
    logic [3:0]  e_fl;
    logic        e_fwr, e_rw, e_mw;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t x, input logic vld, input logic [3:0] wa, input logic m2r,
                       input logic hold, input logic flush);
    bus.fwdSelA = x.fa;   bus.fwdSelB = x.fb;
    bus.RD1E = x.rd1;     bus.RD2E = x.rd2;     bus.ExtImmE = x.imm;
    bus.forward_ResultW = x.fw;  bus.forward_ALUResultM = x.fm;
    bus.ALUSrcE = x.asrc; bus.ALUControlE = x.op;
    bus.condE = x.cc;     bus.FlagsE = x.fl;
    bus.FlagWE = x.fwe;   bus.RegWE = x.rwe;    bus.MemWE = x.mwe;
    bus.MemtoRegE = m2r;  bus.WA3E = wa;        bus.validE = vld;
    bus.holdM = hold;     bus.flushE = flush;
  endtask

  function automatic vec_t mkop(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] fl, input logic fwe);
    vec_t x;
    x = '{2'b00, 2'b00, a, b, 32'h0, 32'h0, 32'h0, 1'b0, op, 4'b1110, fl, fwe, 1'b1, 1'b0,
          32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    return x;
  endfunction

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rd,
                                       input logic [31:0] w, input logic [31:0] m);
    return (s == 2'b01) ? w : (s == 2'b10) ? m : rd;
  endfunction

  // Signed results are formed in 64-bit arithmetic and range-checked, rather than via sign-bit rules.
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fin, output logic [31:0] r, output logic [3:0] fo);
    longint sr;
    logic   c, v;
    c = fin[1];
    v = fin[0];
    r = 32'h0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
        sr = longint'($signed(a)) + longint'($signed(b));
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      3'd7: r = a & ~b;
      default: r = 32'h0;
    endcase
    fo = {r[31], r == 32'h0, c, v};
  endfunction

  initial begin
    vec_t        x;
    logic [31:0] a, mb, r, e_res, e_wd;
    logic [3:0]  fo, e_wa;
    logic        ok, e_fwr, e_vld, e_rw, e_mw, e_m2r, hold, flush, vld, m2r;
    logic [63:0] p;
    int          stalls;

    vt[0] = '{2'b00, 2'b00, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h0, 32'h0, 1'b1, 3'd0, 4'b1110, 4'b0000,
              1'b1, 1'b1, 1'b0, 32'h8000_0000, 4'b1001, 1'b1, 1'b1, 1'b0};
    vt[1] = '{2'b10, 2'b00, 32'h0000_DEAD, 32'h5, 32'h0, 32'h0, 32'h5, 1'b0, 3'd1, 4'b1110, 4'b0000,
              1'b1, 1'b1, 1'b0, 32'h0, 4'b0110, 1'b1, 1'b1, 1'b0};
    vt[2] = '{2'b00, 2'b00, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 4'b0000, 4'b0000,
              1'b1, 1'b1, 1'b1, 32'h7, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[3] = '{2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd2, 4'b1110, 4'b0011,
              1'b1, 1'b1, 1'b0, 32'h00F0_00F0, 4'b0011, 1'b1, 1'b1, 1'b0};
    vt[4] = '{2'b00, 2'b01, 32'hAAAA_5555, 32'h0, 32'h0, 32'hAAAA_5555, 32'h0, 1'b0, 3'd4, 4'b1110, 4'b1000,
              1'b1, 1'b1, 1'b0, 32'h0, 4'b0100, 1'b1, 1'b1, 1'b0};
    vt[5] = '{2'b00, 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 1'b0, 3'd7, 4'b1110, 4'b0110,
              1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 4'b1010, 1'b1, 1'b1, 1'b0};
    vt[6] = '{2'b00, 2'b00, 32'h1, 32'h55, 32'h0, 32'h0, 32'h0, 1'b1, 3'd5, 4'b0001, 4'b1001,
              1'b1, 1'b1, 1'b0, 32'h0, 4'b0101, 1'b1, 1'b1, 1'b0};
    vt[7] = '{2'b00, 2'b00, 32'h3, 32'h5, 32'h0, 32'h0, 32'h0, 1'b0, 3'd1, 4'b1010, 4'b0000,
              1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b1, 1'b1, 1'b1};
    vt[8] = '{2'b00, 2'b00, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 4'b1111, 4'b0000,
              1'b1, 1'b1, 1'b1, 32'h2, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[9] = '{2'b11, 2'b11, 32'h1, 32'h10, 32'h0, 32'h1000, 32'h100, 1'b0, 3'd3, 4'b1110, 4'b0000,
              1'b1, 1'b1, 1'b0, 32'h11, 4'b0000, 1'b1, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    drive(mkop(3'd0, 32'h0, 32'h0, 4'h0, 1'b0), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_validM", bus.validM, 0);
    chk("rst_ALUResultM", bus.ALUResultM, 0);
    chk("rst_WriteDataM", bus.WriteDataM, 0);
    chk("rst_WA3M", bus.WA3M, 0);
    chk("rst_ctrlM", {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM}, 0);
    chk("rst_stallE", bus.stallE, 0);
    chk("rst_FlagsWr", bus.FlagsWr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      drive(vt[i], 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      #2;
      chk($sformatf("vec%0d_FlagsWr", i), bus.FlagsWr, vt[i].e_fwr);
      chk($sformatf("vec%0d_stallE", i), bus.stallE, 0);
      if (vt[i].e_fwr) chk($sformatf("vec%0d_FlagsOut", i), bus.FlagsOut, vt[i].e_fl);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ALUResultM", i), bus.ALUResultM, vt[i].e_res);
      chk($sformatf("vec%0d_validM", i), bus.validM, 1);
      chk($sformatf("vec%0d_RegWriteM", i), bus.RegWriteM, vt[i].e_rw);
      chk($sformatf("vec%0d_MemWriteM", i), bus.MemWriteM, vt[i].e_mw);
    end

    // MUL 0x1234 * 0x10: stall T..T+8, bubbles, product visible from T+10
    drive(mkop(3'd6, 32'h1234, 32'h10, 4'b0010, 1'b1), 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= MUL_CYC; i++) begin
      #2;
      chk($sformatf("mul_stall_T%0d", i), bus.stallE, 1);
      chk($sformatf("mul_nofwr_T%0d", i), bus.FlagsWr, 0);
      @(posedge clk); #1;
      chk($sformatf("mul_bubble_T%0d", i), bus.validM, 0);
    end
    #2;
    chk("mul_done_stall", bus.stallE, 0);
    chk("mul_done_FlagsWr", bus.FlagsWr, 1);
    chk("mul_done_FlagsOut", bus.FlagsOut, 4'b0010);
    @(posedge clk); #1;
    bus.validE = 1'b0;
    chk("mul_ALUResultM", bus.ALUResultM, 32'h12340);
    chk("mul_validM", bus.validM, 1);
    chk("mul_RegWriteM", bus.RegWriteM, 1);
    chk("mul_WA3M", bus.WA3M, 5);

    // MUL flushed at T+3
    drive(mkop(3'd6, 32'h55, 32'h3, 4'b0000, 1'b1), 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) bus.flushE = 1'b1;
      if (i == 4) begin
        bus.flushE = 1'b0;
        bus.validE = 1'b0;
      end
      #2;
      chk($sformatf("flush_nofwr_T%0d", i), bus.FlagsWr, 0);
      if (i == 4) chk("flush_stall_clear", bus.stallE, 0);
      @(posedge clk); #1;
      chk($sformatf("flush_noM_T%0d", i), {bus.validM, bus.RegWriteM}, 0);
    end

    // holdM keeps an older M entry through the whole MUL and 3 cycles of DONE
    x = mkop(3'd0, 32'hAB0, 32'h0, 4'b0000, 1'b0);
    x.imm  = 32'hC;
    x.asrc = 1'b1;
    drive(x, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("hold_pre_ALUResultM", bus.ALUResultM, 32'hABC);
    drive(mkop(3'd6, 32'h7, 32'h9, 4'b0000, 1'b0), 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MUL_CYC + 4; i++) begin
      #2;
      chk($sformatf("hold_stall_T%0d", i), bus.stallE, 1);
      @(posedge clk); #1;
      chk($sformatf("hold_keep_T%0d", i), {bus.validM, bus.ALUResultM}, {1'b1, 32'hABC});
    end
    bus.holdM = 1'b0;
    #2;
    chk("hold_release_stall", bus.stallE, 0);
    @(posedge clk); #1;
    bus.validE = 1'b0;
    chk("hold_product", bus.ALUResultM, 32'd63);
    chk("hold_product_valid", bus.validM, 1);

    // Asynchronous reset at T+4 of a new MUL
    drive(mkop(3'd6, 32'h100, 32'h3, 4'b0000, 1'b1), 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    bus.holdM  = 1'b0;
    bus.validE = 1'b0;
    rst        = 1'b1;
    #1;
    chk("arst_validM", bus.validM, 0);
    chk("arst_ALUResultM", bus.ALUResultM, 0);
    chk("arst_ctrlM", {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WA3M}, 0);
    chk("arst_stallE", bus.stallE, 0);
    chk("arst_FlagsWr", bus.FlagsWr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(mkop(3'd0, 32'h2, 32'h3, 4'b0000, 1'b0), 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    #2;
    chk("arst_idle_stall", bus.stallE, 0);
    @(posedge clk); #1;
    chk("arst_idle_add", {bus.validM, bus.ALUResultM}, {1'b1, 32'h5});

    // Random single-cycle ops with hold/flush/invalid slots vs model
    {e_vld, e_rw, e_mw, e_m2r, e_res, e_wd, e_wa} = '0;
    for (int i = 0; i < 300; i++) begin
      x.op = 3'($urandom_range(0, 7));
      if (x.op == 3'd6) x.op = 3'd1;
      x.fa = 2'($urandom_range(0, 3));   x.fb = 2'($urandom_range(0, 3));
      x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
      x.fw = $urandom;  x.fm = $urandom;
      if ($urandom_range(0, 5) == 0) x.rd2 = x.rd1;
      if ($urandom_range(0, 7) == 0) x.rd1 = 32'h7FFF_FFFF;
      x.asrc = 1'($urandom_range(0, 1));
      x.cc = 4'($urandom_range(0, 15));  x.fl = 4'($urandom_range(0, 15));
      x.fwe = 1'($urandom_range(0, 1));  x.rwe = 1'($urandom_range(0, 1));
      x.mwe = 1'($urandom_range(0, 1));
      vld   = ($urandom_range(0, 7) != 0);
      m2r   = 1'($urandom_range(0, 1));
      hold  = (i > 0) && ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);

      a  = pick(x.fa, x.rd1, x.fw, x.fm);
      mb = pick(x.fb, x.rd2, x.fw, x.fm);
      ref_alu(x.op, a, x.asrc ? x.imm : mb, x.fl, r, fo);
      ok    = vld && cond_ok(x.cc, x.fl);
      e_fwr = ok && x.fwe && !flush;
      if (!hold) begin
        if (flush) begin
          {e_vld, e_rw, e_mw, e_m2r} = '0;
        end else begin
          e_vld = vld;          e_rw = ok && x.rwe;
          e_mw  = ok && x.mwe;  e_m2r = vld && m2r;
          e_res = r;            e_wd = mb;    e_wa = 4'(i);
        end
      end

      drive(x, vld, 4'(i), m2r, hold, flush);
      #2;
      chk($sformatf("rnd%0d_FlagsWr", i), bus.FlagsWr, e_fwr);
      chk($sformatf("rnd%0d_stallE", i), bus.stallE, hold);
      if (e_fwr) chk($sformatf("rnd%0d_FlagsOut", i), bus.FlagsOut, fo);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_ctrlM", i), {bus.validM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM},
          {e_vld, e_rw, e_mw, e_m2r});
      if (e_vld) chk($sformatf("rnd%0d_dataM", i), {bus.ALUResultM, bus.WriteDataM, bus.WA3M},
                     {e_res, e_wd, e_wa});
    end

    // Random multiplies: stall length, flags and low-word product
    for (int i = 0; i < 6; i++) begin
      x = mkop(3'd6, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      if (i == 0) x.rd1 = 32'h0;
      if (i == 1) x.rd2 = 32'hFFFF_FFFF;
      p = {32'h0, x.rd1} * {32'h0, x.rd2};
      drive(x, 1'b1, 4'(i + 8), 1'b1, 1'b0, 1'b0);
      stalls = 0;
      #2;
      while (bus.stallE && stalls < 20) begin
        stalls++;
        @(posedge clk); #3;
      end
      chk($sformatf("rmul%0d_stall_cycles", i), stalls, MUL_CYC + 1);
      chk($sformatf("rmul%0d_FlagsWr", i), bus.FlagsWr, 1);
      chk($sformatf("rmul%0d_FlagsOut", i), bus.FlagsOut, {p[31], p[31:0] == 32'h0, x.fl[1:0]});
      @(posedge clk); #1;
      bus.validE = 1'b0;
      chk($sformatf("rmul%0d_result", i), {bus.validM, bus.MemtoRegM, bus.ALUResultM},
          {1'b1, 1'b1, p[31:0]});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
